cacheline_adaptor: RTL
======================

Name: cacheline_adaptor

Overview:
- Memory-side responder for the cache `pmem_*` line interface: serves 256-bit line read/write requests from the instruction or data cache.
- Converts each request into a 4-beat, 64-bit burst transaction on the physical-memory/DRAM bus.
- Sits between the cache (`pmem_read`/`pmem_write`/`pmem_resp`) and the burst memory model or arbiter.
- Completes exactly one line transfer per request with a single-cycle `resp_o` pulse.

Parameters:
- LINE_WIDTH, 256, cache line width in bits.
- BURST_WIDTH, 64, burst beat width in bits; beat count = LINE_WIDTH/BURST_WIDTH = 4.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- line_i  input  256  write line from cache (`pmem_wdata`).
- line_o  output  256  read line to cache (`pmem_rdata`).
- address_i  input  32  line address from cache (`pmem_address`).
- read_i  input  1  line read request (`pmem_read`).
- write_i  input  1  line write request (`pmem_write`).
- resp_o  output  1  line transfer complete (`pmem_resp`).
- burst_i  input  64  read beat from memory.
- burst_o  output  64  write beat to memory.
- address_o  output  32  burst address, 32-byte aligned.
- read_o  output  1  burst read request.
- write_o  output  1  burst write request.
- resp_i  input  1  memory beat handshake; one beat per cycle high.

Behaviour:
- Reset (rst=0, any time, including mid-burst):
  - state goes to IDLE; beat counter goes to 0.
  - `line_o`, `burst_o`, `address_o`, `read_o`, `write_o`, `resp_o` all go to 0.
  - The line buffer is cleared.
  - An in-flight burst is abandoned; it is not resumed after reset.
- Beat order: beat k carries line bits [64k+63:64k]; beat 0 first.
- States: IDLE, READ, WRITE, DONE. All outputs are registered or decoded from state and registers only; there are no combinational paths from inputs to outputs.
- IDLE:
  - `read_i`=1: latch `{address_i[31:5],5'b0}` into `address_o`, counter=0, go to READ.
  - `write_i`=0 and `read_i`=0: stay in IDLE.
  - `write_i`=1 with `read_i`=0: latch the aligned address and `line_i` into the buffer, counter=0, go to WRITE.
  - `read_i` and `write_i` both high: illegal from the cache; the read takes priority.
  - `resp_i` in IDLE is ignored.
- READ:
  - `read_o`=1 for every cycle in READ; `address_o` is held stable.
  - Each edge with `resp_i`=1 stores `burst_i` into buffer beat[counter], then counter+1.
  - Gaps (`resp_i`=0) are allowed between beats; the counter holds.
  - When beat 3 is stored: go to DONE. `read_o` is 0 in the next cycle.
- WRITE:
  - `write_o`=1 for every cycle in WRITE; `burst_o` = buffer beat[counter].
  - Each edge with `resp_i`=1 advances the counter; gaps hold the current beat.
  - When beat 3 is accepted: go to DONE. `write_o` is 0 in the next cycle.
- DONE:
  - `resp_o`=1 for exactly one cycle, then go to IDLE.
  - `read_i`, `write_i` and `resp_i` are ignored in DONE. The cache drops its request on seeing `resp_o`.
  - The earliest next request is accepted in the IDLE cycle that follows.
- `line_o` holds the buffer contents from the cycle of `resp_o` until the next read completes. A write does not alter `line_o`.
- Latency with `resp_i` held high:
  - request sampled at edge E0; beats sampled at E1–E4; `resp_o` high during E4–E5.
  - 5 cycles request-to-response.
- `address_i`, `line_i`, `read_i`, `write_i` are sampled only in IDLE; changes during a transaction have no effect.
- Counter is 2 bits; it wraps from 3 to 0 only on the DONE transition.

Test Plan:
- Reset then idle: rst=0 mid-simulation -> all outputs 0. After release with `read_i`=`write_i`=0 for 10 cycles -> `read_o`, `write_o`, `resp_o` stay 0.
- Back-to-back read:
  - stimulus: `read_i`=1, `address_i`=0x0000_1234; memory returns 0x1111…, 0x2222…, 0x3333…, 0x4444… with `resp_i` high 4 consecutive cycles.
  - response: `address_o`=0x0000_1220; `resp_o` pulses once, 5 cycles after the request; `line_o`=0x4444…_3333…_2222…_1111…
- Write with gaps:
  - stimulus: `write_i`=1, `line_i`=0xDDDD…_CCCC…_BBBB…_AAAA…; `resp_i` pattern 1,0,1,0,0,1,1.
  - response: `burst_o` sequence AAAA, BBBB, CCCC, DDDD, each held through gaps; `write_o` drops after the 4th accepted beat; single `resp_o`.
- Simultaneous `read_i`=`write_i`=1 -> READ performed, `write_o` never asserts, `line_o` unchanged by `line_i`.
- Reset mid-read: rst asserted after beat 2 -> `read_o`=0 and `line_o`=0 immediately; a new read after release collects a full 4 beats correctly.
- Request held through DONE: `read_i` kept high after `resp_o` -> exactly one new READ starts in the following IDLE cycle, with no duplicate `resp_o`.

Source files
------------

// File: rtl/cacheline_adaptor.sv
// Cache-line to DRAM burst adaptor: serves one 256-bit line read or write
// as a 4-beat, 64-bit burst and answers the cache with a one-cycle resp_o.
module cacheline_adaptor #(
   parameter int LINE_WIDTH  = 256,
   parameter int BURST_WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [LINE_WIDTH-1:0]  line_i,
   output logic [LINE_WIDTH-1:0]  line_o,
   input  logic [31:0]            address_i,
   input  logic                   read_i,
   input  logic                   write_i,
   output logic                   resp_o,
   input  logic [BURST_WIDTH-1:0] burst_i,
   output logic [BURST_WIDTH-1:0] burst_o,
   output logic [31:0]            address_o,
   output logic                   read_o,
   output logic                   write_o,
   input  logic                   resp_i
);

   localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
   localparam int CW    = $clog2(BEATS);
   localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t                              state;
   logic [CW-1:0]                       count;
   logic [BEATS-1:0][BURST_WIDTH-1:0]   buffer;
   logic [BEATS-1:0][BURST_WIDTH-1:0]   read_line;

   // Line as it will look once the incoming read beat is merged in; lets
   // line_o be valid in the same cycle resp_o rises.
   // NOTE: every always_comb output gets a full default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      read_line        = buffer;
      read_line[count] = burst_i;
   end

   // NOTE: state uses non-blocking assignments only, so every register sees
   // the pre-edge value of every other register regardless of statement order.
   // NOTE: the line buffer is reset like any other register because a reset
   // must leave no stale line data visible on burst_o or line_o.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         count     <= '0;
         buffer    <= '0;
         line_o    <= '0;
         address_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               count <= '0;
               if (read_i) begin
                  address_o <= address_i & 32'hFFFF_FFE0;
                  state     <= READ;
               end else if (write_i) begin
                  address_o <= address_i & 32'hFFFF_FFE0;
                  buffer    <= line_i;
                  state     <= WRITE;
               end
            end
            READ: begin
               if (resp_i) begin
                  buffer <= read_line;
                  count  <= count + 1'b1;
                  if (count == LAST_BEAT) begin
                     line_o <= read_line;
                     state  <= DONE;
                  end
               end
            end
            WRITE: begin
               if (resp_i) begin
                  count <= count + 1'b1;
                  if (count == LAST_BEAT) state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Handshake outputs decode straight from the state register.
   assign read_o  = (state == READ);
   assign write_o = (state == WRITE);
   assign resp_o  = (state == DONE);
   assign burst_o = buffer[count];

endmodule
